inst_mem_loader: RTL and testbench
==================================

# inst_mem_loader

Boot-time writer for the byte-addressed instruction memory. It accepts a framed byte stream over a valid/ready handshake, writes the payload bytes into consecutive instruction-memory byte locations, and verifies an XOR checksum. It holds the core in reset until a load completes cleanly. It sits between the host link and the write port of the instruction memory, while the fetch path reads the same memory.

## Interface
Parameters:
- MEM_BYTES, 256, instruction-memory size in bytes.
- BASE_ADDR, 0, byte address where the first payload byte is written.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- mem_we  output  1  byte write strobe to the instruction memory.
- mem_addr  output  64  byte address of the write.
- mem_wdata  output  8  byte to write.
- busy  output  1  high while in LEN0, LEN1, DATA or CHK.
- done  output  1  high while in DONE.
- err  output  1  high while in ERR.
- core_hold  output  1  holds the core in reset; low only in DONE.

## Operation
Frame format (little-endian), in this order:
- count_lo, count_hi: the 16-bit word count N.
- 4·N payload bytes: byte k goes to BASE_ADDR+k, least-significant byte of each instruction first.
- One checksum byte: the XOR of all payload bytes. The header bytes are excluded from the checksum.

A byte is transferred on a rising edge where in_valid && in_ready. in_ready is high only in LEN0, LEN1, DATA and CHK, and is decoded from the registered state only.

State machine:
- IDLE: start → LEN0, clearing the byte index and the running checksum.
- LEN0: on accept, latch count_lo → LEN1.
- LEN1: on accept, latch count_hi, then:
  - if BASE_ADDR + 4·N > MEM_BYTES → ERR, with no writes issued;
  - else if N == 0 → CHK;
  - else → DATA.
- DATA: on accept, issue a write of the byte, XOR it into the checksum and increment the index. After accepting byte 4·N−1 → CHK.
- CHK: on accept, compare the byte with the running checksum. Equal → DONE; else → ERR.
- DONE and ERR: hold. start → LEN0 and restarts a full frame.

Rules:
- start outside IDLE/DONE/ERR is ignored.
- Size arithmetic uses 18 bits for 4·N and 64 bits for addresses, with no truncation.
- The index counter is 18 bits.
- Bad-checksum loads leave their written bytes in memory; err flags them as invalid and core_hold stays 1.

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, err 0, core_hold 1; state IDLE.
- Reset is asynchronous. Asserting it mid-frame returns the loader to IDLE immediately, and any pending write is dropped.
- Write latency: mem_we, mem_addr and mem_wdata are registered. They are valid for exactly one cycle, the cycle after the accepting edge, with one pulse per payload byte.
- Throughput: one byte per cycle with in_valid held high, so the writes run back-to-back.
- Gaps in in_valid stall the loader with no state change. The address sequence stays contiguous regardless of gaps.
- done, err, busy and core_hold change on the same edge as the state transition. The DONE transition occurs on the CHK accept edge, so the last payload write has already completed before done rises.
- Bytes presented in IDLE, DONE or ERR are not consumed, because in_ready is 0.
- start is sampled on the edge; a start pulse and in_valid in the same cycle do not consume a byte, since in_ready is 0 in the start state.

## Structure
- Shared package holds:
  - the state enum (IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR);
  - the header length constant (2 bytes);
  - the checksum width constant (8).
- Single module; no sub-module is warranted. The datapath is the index counter, the checksum register and the write register.

## Test plan
- Reset: assert reset mid-simulation → every output at its reset value, core_hold=1, in_ready=0.
- Good load: start; send 01 00 13 03 10 00 00 → four writes (0x0:0x13, 0x1:0x03, 0x2:0x10, 0x3:0x00); then done=1, core_hold=0, err=0.
- Bad checksum: same frame, checksum byte FF → the same four writes, then err=1, core_hold=1, done=0.
- Overflow: MEM_BYTES=256, header 41 00 → err=1 on the edge after the second header byte; no mem_we ever asserts.
- Stall/zero-length: payload sent with in_valid toggling every other cycle → addresses 0..3 are contiguous, with one pulse per accepted byte. Separately, frame 00 00 00 → done=1 with no writes.
- Reset mid-DATA: reset after 2 payload bytes → outputs at reset values. A following start with a full good frame writes again from BASE_ADDR and reaches done=1.

Source files
------------

// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package inst_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int HDR_BYTES = 2;
  localparam int CSUM_W    = 8;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Host byte stream plus instruction-memory byte write port.
interface inst_mem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot loader: parses a length-prefixed byte frame, writes the payload into
// instruction memory and releases the core only after a clean XOR checksum.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256,
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  inst_mem_loader_if.slave        bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    core_hold
);

  state_e            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [17:0]       idx_q, idx_d;
  logic [CSUM_W-1:0] csum_q, csum_d;
  logic              we_q, we_d;
  logic [63:0]       addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic              ready;
  logic              accept;
  logic [15:0]       hdr_n;
  logic [17:0]       frame_bytes;
  logic [17:0]       payload_bytes;
  logic [64:0]       frame_end;
  logic              overflow;
  logic              last_byte;

  // Ready comes from the registered state only, never from in_valid.
  assign ready  = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                  (state_q == ST_DATA) || (state_q == ST_CHK);
  assign accept = bus.in_valid && ready;

  // 65-bit compare so a large BASE_ADDR cannot wrap past the limit check.
  assign hdr_n         = {bus.in_data, count_q[7:0]};
  assign frame_bytes   = {hdr_n, 2'b00};
  assign frame_end     = {1'b0, BASE_ADDR} + {47'd0, frame_bytes};
  assign overflow      = frame_end > 65'(MEM_BYTES);
  assign payload_bytes = {count_q, 2'b00};
  assign last_byte     = (idx_q + 18'd1) == payload_bytes;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LEN0;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      ST_LEN0: begin
        if (accept) begin
          count_d = {8'd0, bus.in_data};
          state_d = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (accept) begin
          count_d = hdr_n;
          if (overflow)
            state_d = ST_ERR;
          else if (hdr_n == 16'd0)
            state_d = ST_CHK;
          else
            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + {46'd0, idx_q};
          wdata_d = bus.in_data;
          csum_d  = csum_q ^ bus.in_data;
          idx_d   = idx_q + 18'd1;
          if (last_byte)
            state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (accept)
          state_d = (bus.in_data == csum_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign busy      = ready;
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_ERR);
  assign core_hold = (state_q != ST_DONE);

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench: stimulus pushes expected writes, a monitor pops and checks them.
module tb_inst_mem_loader;
  import inst_mem_loader_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy, done, err, core_hold;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t exp_q[$];

  inst_mem_loader_if bus ();

  inst_mem_loader #(.MEM_BYTES(256), .BASE_ADDR(64'd0)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .core_hold (core_hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: samples 1 time unit after each rising edge.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", bus.mem_addr, e.addr);
          check("wr_data", {56'd0, bus.mem_wdata}, {56'd0, e.data});
          $display("write addr=%0h data=%02h", bus.mem_addr, bus.mem_wdata);
        end
      end
    end
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready stayed %b, expected 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gap);
    int n;
    wr_t e;
    n = {f[1], f[0]};
    if (4 * n <= 256) begin
      for (int k = 0; k < 4 * n; k++) begin
        e.addr = 64'(k);
        e.data = f[HDR_BYTES + k];
        exp_q.push_back(e);
      end
    end
    for (int i = 0; i < f.size(); i++) send_byte(f[i], gap);
  endtask

  task automatic expect_end(input string name, input bit exp_done);
    int t = 0;
    while (!(done || err) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({name, "_done"}, {63'd0, done}, {63'd0, exp_done});
    check({name, "_err"}, {63'd0, err}, {63'd0, !exp_done});
    check({name, "_hold"}, {63'd0, core_hold}, {63'd0, !exp_done});
    check({name, "_busy"}, {63'd0, busy}, 64'd0);
    check({name, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    $display("frame %s: done=%b err=%b core_hold=%b", name, done, err, core_hold);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
    check({name, "_mem_we"}, {63'd0, bus.mem_we}, 64'd0);
    check({name, "_mem_addr"}, bus.mem_addr, 64'd0);
    check({name, "_mem_wdata"}, {56'd0, bus.mem_wdata}, 64'd0);
    check({name, "_busy"}, {63'd0, busy}, 64'd0);
    check({name, "_done"}, {63'd0, done}, 64'd0);
    check({name, "_err"}, {63'd0, err}, 64'd0);
    check({name, "_hold"}, {63'd0, core_hold}, 64'd1);
    $display("reset %s: outputs sampled", name);
  endtask

  initial begin
    logic [7:0] good[$];
    logic [7:0] bad[$];
    logic [7:0] zero[$];
    wr_t e;
    good = '{8'h01, 8'h00, 8'h13, 8'h03, 8'h10, 8'h00, 8'h00};
    bad  = '{8'h01, 8'h00, 8'h13, 8'h03, 8'h10, 8'h00, 8'hFF};
    zero = '{8'h00, 8'h00, 8'h00};

    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);

    // Good load
    pulse_start();
    send_frame(good, 1'b0);
    expect_end("good", 1'b1);

    // Bytes offered in DONE are not taken
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    @(negedge clk);
    check("done_in_ready", {63'd0, bus.in_ready}, 64'd0);
    bus.in_valid = 1'b0;

    // Bad checksum: writes still happen, err flags the load
    pulse_start();
    send_frame(bad, 1'b0);
    expect_end("badcsum", 1'b0);

    // Overflow: 0x41 words = 260 bytes > 256
    pulse_start();
    send_byte(8'h41, 1'b0);
    send_byte(8'h00, 1'b0);
    check("ovf_err_next_edge", {63'd0, err}, 64'd1);
    repeat (3) @(negedge clk);
    expect_end("overflow", 1'b0);

    // Stalled payload with in_valid toggling
    pulse_start();
    send_frame(good, 1'b1);
    expect_end("stall", 1'b1);

    // Zero-length frame
    pulse_start();
    send_frame(zero, 1'b0);
    expect_end("zero", 1'b1);

    // Reset mid-DATA after two payload bytes
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    e.addr = 64'd0; e.data = 8'h13; exp_q.push_back(e);
    e.addr = 64'd1; e.data = 8'h03; exp_q.push_back(e);
    send_byte(8'h13, 1'b0);
    send_byte(8'h03, 1'b0);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_data");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_data_drained", 64'(exp_q.size()), 64'd0);

    pulse_start();
    send_frame(good, 1'b0);
    expect_end("after_reset", 1'b1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
